// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the ALU issue controller.
// Optional build macro used by the top: ALU_ISSUE_DIV0_FAST_EN.
package alu_issue_pkg;

    // ALU operation codes driven on alu_op
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    // M-extension result selects
    localparam logic [1:0] MSEL_QUO = 2'b00;
    localparam logic [1:0] MSEL_REM = 2'b01;
    localparam logic [1:0] MSEL_LSB = 2'b10;
    localparam logic [1:0] MSEL_MSB = 2'b11;

    // Encoding constants for the OP instruction class
    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        LAT_ALU = 2'd0,
        LAT_MUL = 2'd1,
        LAT_DIV = 2'd2
    } lat_class_e;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of an OP-class instruction into ALU/M-unit controls.
import alu_issue_pkg::*;

module alu_issue_decode (
    input  logic [6:0]  funct7,
    input  logic [2:0]  funct3,
    input  logic [6:0]  opcode,
    output logic [3:0]  alu_op,
    output logic [1:0]  sn,
    output logic        mul_en,
    output logic        div_en,
    output logic [1:0]  m_sel,
    output logic        result_sel,
    output lat_class_e  lat_class,
    output logic        illegal
);

    // Map funct7/funct3 to controls; M ops leave the ALU on ADD
    always_comb begin
        alu_op     = ALU_ADD;
        sn         = 2'b00;
        mul_en     = 1'b0;
        div_en     = 1'b0;
        m_sel      = MSEL_QUO;
        result_sel = 1'b0;
        lat_class  = LAT_ALU;
        illegal    = 1'b0;

        if (opcode != OPC_OP) begin
            illegal = 1'b1;
        end else if (funct7 == F7_MEXT) begin
            result_sel = 1'b1;
            mul_en     = ~funct3[2];
            div_en     = funct3[2];
            lat_class  = funct3[2] ? LAT_DIV : LAT_MUL;
            case (funct3)
                3'b000:  begin m_sel = MSEL_LSB; sn = 2'b11; end
                3'b001:  begin m_sel = MSEL_MSB; sn = 2'b11; end
                3'b010:  begin m_sel = MSEL_MSB; sn = 2'b10; end
                3'b011:  begin m_sel = MSEL_MSB; sn = 2'b00; end
                3'b100:  begin m_sel = MSEL_QUO; sn = 2'b11; end
                3'b101:  begin m_sel = MSEL_QUO; sn = 2'b00; end
                3'b110:  begin m_sel = MSEL_REM; sn = 2'b11; end
                default: begin m_sel = MSEL_REM; sn = 2'b00; end
            endcase
        end else if (funct7 == F7_BASE || funct7 == F7_ALT) begin
            if (funct7 == F7_ALT && funct3 != 3'b000 && funct3 != 3'b101)
                illegal = 1'b1;
            case (funct3)
                3'b000:  alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
                3'b001:  alu_op = ALU_SLL;
                3'b010:  alu_op = ALU_SLT;
                3'b011:  alu_op = ALU_SLTU;
                3'b100:  alu_op = ALU_XOR;
                3'b101:  alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                3'b110:  alu_op = ALU_OR;
                default: alu_op = ALU_AND;
            endcase
        end else begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the RV32IM ALU datapath: accepts one OP instruction,
// holds its controls for a fixed latency, then pulses result_valid.
// Build macro ALU_ISSUE_DIV0_FAST_EN: divides by zero finish after one EXEC cycle.
// Handshake: an instruction is taken on a rising edge where instr_valid and
// instr_ready are both high and flush_i is low; instr_ready is high only in IDLE.
import alu_issue_pkg::*;

module alu_issue_ctrl #(
    parameter int ALU_LAT = 1,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 34
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    input  logic [6:0] opcode,
    input  logic [4:0] rd_i,
    input  logic       flush_i,
    input  logic       div_zero_i,
    output logic [3:0] alu_op,
    output logic [1:0] sn,
    output logic       Mul_en,
    output logic       Div_en,
    output logic [1:0] M_sel,
    output logic       result_sel,
    output logic       stall_o,
    output logic       result_valid,
    output logic [4:0] rd_o,
    output logic       wb_en,
    output logic       illegal_o
);

    localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ?
                             ((DIV_LAT > ALU_LAT) ? DIV_LAT : ALU_LAT) :
                             ((MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT);
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_load;
    logic             accept, take;

    logic [3:0]  dec_alu_op;
    logic [1:0]  dec_sn, dec_m_sel;
    logic        dec_mul_en, dec_div_en, dec_result_sel, dec_illegal;
    lat_class_e  dec_lat;

    logic [3:0]  alu_op_q;
    logic [1:0]  sn_q, m_sel_q;
    logic        result_sel_q, mul_q, div_q, illegal_q;
    logic [4:0]  rd_q;

    alu_issue_decode u_decode (
        .funct7     (funct7),
        .funct3     (funct3),
        .opcode     (opcode),
        .alu_op     (dec_alu_op),
        .sn         (dec_sn),
        .mul_en     (dec_mul_en),
        .div_en     (dec_div_en),
        .m_sel      (dec_m_sel),
        .result_sel (dec_result_sel),
        .lat_class  (dec_lat),
        .illegal    (dec_illegal)
    );

    // A flush in the accept cycle cancels the accept entirely
    assign accept = instr_valid && (state_q == S_IDLE) && !flush_i;
    assign take   = accept && !dec_illegal;

    // Counter preload: latency-1 of the decoded class
    always_comb begin
        case (dec_lat)
            LAT_MUL: cnt_load = CNT_W'(MUL_LAT - 1);
            LAT_DIV: cnt_load = CNT_W'(DIV_LAT - 1);
            default: cnt_load = CNT_W'(ALU_LAT - 1);
        endcase
`ifdef ALU_ISSUE_DIV0_FAST_EN
        if (dec_lat == LAT_DIV && div_zero_i)
            cnt_load = '0;
`endif
    end

`ifndef ALU_ISSUE_DIV0_FAST_EN
    logic unused_div_zero;
    assign unused_div_zero = div_zero_i;
`endif

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (take) state_d = S_EXEC;
            S_EXEC:  if (cnt_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i)
            state_d = S_IDLE;
    end

    // State register and latency counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (flush_i)
                cnt_q <= '0;
            else if (take)
                cnt_q <= cnt_load;
            else if (state_q == S_EXEC && cnt_q != '0)
                cnt_q <= cnt_q - 1'b1;
        end
    end

    // Control registers: loaded on a legal accept, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op_q     <= '0;
            sn_q         <= '0;
            m_sel_q      <= '0;
            result_sel_q <= 1'b0;
            mul_q        <= 1'b0;
            div_q        <= 1'b0;
            rd_q         <= '0;
            illegal_q    <= 1'b0;
        end else begin
            illegal_q <= accept && dec_illegal;
            if (take) begin
                alu_op_q     <= dec_alu_op;
                sn_q         <= dec_sn;
                m_sel_q      <= dec_m_sel;
                result_sel_q <= dec_result_sel;
                mul_q        <= dec_mul_en;
                div_q        <= dec_div_en;
                rd_q         <= rd_i;
            end
        end
    end

    assign instr_ready  = (state_q == S_IDLE);
    assign stall_o      = (state_q != S_IDLE);
    assign result_valid = (state_q == S_DONE) && !flush_i;
    assign wb_en        = result_valid && (rd_q != 5'd0);
    assign alu_op       = alu_op_q;
    assign sn           = sn_q;
    assign M_sel        = m_sel_q;
    assign result_sel   = result_sel_q;
    assign Mul_en       = mul_q && (state_q != S_IDLE);
    assign Div_en       = div_q && (state_q != S_IDLE);
    assign rd_o         = rd_q;
    assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [6:0] opcode;
    logic [4:0] rd_i;
    logic       flush_i;
    logic       div_zero_i;
    logic [3:0] alu_op;
    logic [1:0] sn;
    logic       Mul_en;
    logic       Div_en;
    logic [1:0] M_sel;
    logic       result_sel;
    logic       stall_o;
    logic       result_valid;
    logic [4:0] rd_o;
    logic       wb_en;
    logic       illegal_o;

    int n_checks = 0;
    int n_fails  = 0;

`ifdef ALU_ISSUE_DIV0_FAST_EN
    localparam int DIV0_LAT = 2;
`else
    localparam int DIV0_LAT = 35;
`endif

    alu_issue_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .funct7       (funct7),
        .funct3       (funct3),
        .opcode       (opcode),
        .rd_i         (rd_i),
        .flush_i      (flush_i),
        .div_zero_i   (div_zero_i),
        .alu_op       (alu_op),
        .sn           (sn),
        .Mul_en       (Mul_en),
        .Div_en       (Div_en),
        .M_sel        (M_sel),
        .result_sel   (result_sel),
        .stall_o      (stall_o),
        .result_valid (result_valid),
        .rd_o         (rd_o),
        .wb_en        (wb_en),
        .illegal_o    (illegal_o)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single accept edge; returns in cycle 1 after accept
    task automatic issue(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op,
                         input logic [4:0] rd, input logic dz);
        funct7      = f7;
        funct3      = f3;
        opcode      = op;
        rd_i        = rd;
        div_zero_i  = dz;
        instr_valid = 1'b1;
        check("ready_before_issue", 32'(instr_ready), 32'd1);
        step();
        instr_valid = 1'b0;
        div_zero_i  = 1'b0;
    endtask

    // Count cycles from accept until result_valid, bounded by max_c
    task automatic wait_rv(input int max_c, output int lat);
        lat = 1;
        while (result_valid !== 1'b1 && lat < max_c) begin
            step();
            lat++;
        end
    endtask

    int lat;
    int bad;
    int seen;

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; funct7 = '0; funct3 = '0; opcode = '0;
        rd_i = '0; flush_i = 1'b0; div_zero_i = 1'b0;
        #3;
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_rv", 32'(result_valid), 32'd0);
        check("rst_outs", {alu_op, sn, Mul_en, Div_en, M_sel, result_sel, rd_o, wb_en, illegal_o}, 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // ADD x5: result_valid two cycles after accept
        issue(7'b0000000, 3'b000, 7'b0110011, 5'd5, 1'b0);
        check("add_c1_stall", 32'(stall_o), 32'd1);
        check("add_c1_ready", 32'(instr_ready), 32'd0);
        check("add_c1_rv", 32'(result_valid), 32'd0);
        step();
        check("add_c2_rv", 32'(result_valid), 32'd1);
        check("add_c2_wb", 32'(wb_en), 32'd1);
        check("add_c2_rd", 32'(rd_o), 32'd5);
        check("add_c2_op", 32'(alu_op), 32'd0);
        check("add_c2_rsel", 32'(result_sel), 32'd0);
        check("add_c2_mul", 32'(Mul_en), 32'd0);
        step();
        check("add_c3_ready", 32'(instr_ready), 32'd1);
        check("add_c3_rv", 32'(result_valid), 32'd0);
        check("add_c3_stall", 32'(stall_o), 32'd0);

        // SRA rd 7
        issue(7'b0100000, 3'b101, 7'b0110011, 5'd7, 1'b0);
        wait_rv(10, lat);
        check("sra_lat", 32'(lat), 32'd2);
        check("sra_op", 32'(alu_op), 32'd7);
        step();

        // MULHSU rd 3
        issue(7'b0000001, 3'b010, 7'b0110011, 5'd3, 1'b0);
        check("mulhsu_c1_ctl", {Mul_en, Div_en, M_sel, sn, result_sel}, 32'b1_0_11_10_1);
        check("mulhsu_c1_rv", 32'(result_valid), 32'd0);
        step();
        check("mulhsu_c2_ctl", {Mul_en, M_sel, sn}, 32'b1_11_10);
        check("mulhsu_c2_rv", 32'(result_valid), 32'd0);
        check("mulhsu_c2_ready", 32'(instr_ready), 32'd0);
        step();
        check("mulhsu_c3_rv", 32'(result_valid), 32'd1);
        check("mulhsu_c3_wb", 32'(wb_en), 32'd1);
        check("mulhsu_c3_rd", 32'(rd_o), 32'd3);
        check("mulhsu_c3_ctl", {Mul_en, M_sel, sn}, 32'b1_11_10);
        check("mulhsu_c3_ready", 32'(instr_ready), 32'd0);
        step();
        check("mulhsu_c4_ready", 32'(instr_ready), 32'd1);
        check("mulhsu_c4_mul", 32'(Mul_en), 32'd0);
        check("mulhsu_c4_hold", {M_sel, result_sel}, 32'b11_1);

        // MUL rd 1
        issue(7'b0000001, 3'b000, 7'b0110011, 5'd1, 1'b0);
        wait_rv(10, lat);
        check("mul_lat", 32'(lat), 32'd3);
        check("mul_ctl", {M_sel, sn}, 32'b10_11);
        step();

        // DIVU rd 0: long latency, no write-back, controls steady throughout
        issue(7'b0000001, 3'b101, 7'b0110011, 5'd0, 1'b0);
        lat = 1; bad = 0;
        while (result_valid !== 1'b1 && lat < 60) begin
            if (Div_en !== 1'b1 || sn !== 2'b00 || stall_o !== 1'b1) bad++;
            step();
            lat++;
        end
        check("divu_hold_errs", 32'(bad), 32'd0);
        check("divu_lat", 32'(lat), 32'd35);
        check("divu_wb", 32'(wb_en), 32'd0);
        check("divu_div_en", 32'(Div_en), 32'd1);
        step();

        // DIV with rs2 == 0
        issue(7'b0000001, 3'b100, 7'b0110011, 5'd2, 1'b1);
        wait_rv(60, lat);
        check("div0_lat", 32'(lat), 32'(DIV0_LAT));
        check("div0_ctl", {M_sel, sn}, 32'b00_11);
        step();

        // REM flushed 10 cycles after accept
        issue(7'b0000001, 3'b110, 7'b0110011, 5'd9, 1'b0);
        check("rem_ctl", {Div_en, M_sel, sn}, 32'b1_01_11);
        repeat (9) step();
        flush_i = 1'b1;
        check("rem_pre_flush_div", 32'(Div_en), 32'd1);
        step();
        flush_i = 1'b0;
        check("flush_ready", 32'(instr_ready), 32'd1);
        check("flush_div_en", 32'(Div_en), 32'd0);
        check("flush_stall", 32'(stall_o), 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (result_valid !== 1'b0) seen++;
            step();
        end
        check("flush_no_rv", 32'(seen), 32'd0);

        // Illegal: funct7 0100000 with funct3 111
        issue(7'b0100000, 3'b111, 7'b0110011, 5'd4, 1'b0);
        check("ill_pulse", 32'(illegal_o), 32'd1);
        check("ill_ready", 32'(instr_ready), 32'd1);
        check("ill_stall", 32'(stall_o), 32'd0);
        check("ill_rv", 32'(result_valid), 32'd0);
        step();
        check("ill_pulse_end", 32'(illegal_o), 32'd0);

        // Illegal: wrong opcode
        issue(7'b0000000, 3'b000, 7'b0010011, 5'd4, 1'b0);
        check("ill_opc_pulse", 32'(illegal_o), 32'd1);
        check("ill_opc_stall", 32'(stall_o), 32'd0);
        step();

        // Flush in the accept cycle cancels the accept
        funct7 = 7'b0000000; funct3 = 3'b000; opcode = 7'b0110011; rd_i = 5'd8;
        instr_valid = 1'b1; flush_i = 1'b1;
        step();
        instr_valid = 1'b0; flush_i = 1'b0;
        check("flush_acc_stall", 32'(stall_o), 32'd0);
        check("flush_acc_ready", 32'(instr_ready), 32'd1);
        step();
        check("flush_acc_rv", 32'(result_valid), 32'd0);

        // Asynchronous reset in the middle of a DIV
        issue(7'b0000001, 3'b100, 7'b0110011, 5'd4, 1'b0);
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(instr_ready), 32'd1);
        check("arst_stall", 32'(stall_o), 32'd0);
        check("arst_outs", {alu_op, sn, Mul_en, Div_en, M_sel, result_sel, rd_o, wb_en, illegal_o, result_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // First accept after reset: XOR rd 6
        issue(7'b0000000, 3'b100, 7'b0110011, 5'd6, 1'b0);
        wait_rv(10, lat);
        check("xor_lat", 32'(lat), 32'd2);
        check("xor_op", 32'(alu_op), 32'd5);
        check("xor_wb_rd", {27'd0, rd_o} | {26'd0, wb_en, 5'd0}, 32'h26);
        step();
        check("xor_ready", 32'(instr_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequential issue/decode controller that drives the control side of the RV32IM ALU datapath: alu_op, sn, Mul_en, Div_en, M_sel, result_sel.
- Accepts one decoded OP-class instruction (opcode 0110011) per valid/ready handshake.
- Registers and holds the ALU controls stable for the operation's fixed latency, stalling the front end meanwhile.
- Signals result capture with a one-cycle result_valid pulse, plus an rd write enable.

Parameters:
- ALU_LAT, 1, cycles the RV32I ALU path needs before its result is captured (>=1).
- MUL_LAT, 2, cycles MUL/MULH/MULHSU/MULHU hold controls before capture (>=1).
- DIV_LAT, 34, cycles DIV/DIVU/REM/REMU hold controls before capture (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction fields valid.
- instr_ready  out  1  controller can accept; high only in IDLE.
- funct7  in  7  instr[31:25].
- funct3  in  3  instr[14:12].
- opcode  in  7  instr[6:0].
- rd_i  in  5  destination register.
- flush_i  in  1  abort the in-flight operation.
- div_zero_i  in  1  rs2 operand == 0; sampled at acceptance.
- alu_op  out  4  ALU operation code.
- sn  out  2  operand signedness {A_signed, B_signed}.
- Mul_en  out  1  multiplier enable.
- Div_en  out  1  divider enable.
- M_sel  out  2  M result select: 00 QUO, 01 REM, 10 LSB, 11 MSB.
- result_sel  out  1  1 = M-extension result, 0 = RV32I ALU result.
- stall_o  out  1  high while an operation is in flight.
- result_valid  out  1  one-cycle pulse: capture ALU_out now.
- rd_o  out  5  registered destination register.
- wb_en  out  1  equals result_valid when rd_o != 0.
- illegal_o  out  1  one-cycle pulse: unsupported encoding was accepted.

Behaviour:
- Reset (async, rst_n low): state IDLE, counter 0. All outputs 0 except instr_ready = 1.
- States: IDLE, EXEC, DONE.
- IDLE:
  - Accept when instr_valid & instr_ready. On that edge, register the decoded controls, rd_o and latency, then go to EXEC.
  - An illegal encoding is one of: opcode != 0110011; funct7 not in {0000000, 0100000, 0000001}; funct7 = 0100000 with funct3 not in {000, 101}. It is accepted but does not enter EXEC: illegal_o pulses the next cycle, state stays IDLE, no result_valid.
- EXEC:
  - stall_o = 1, instr_ready = 0. Controls held constant.
  - Counter loads latency-1 at accept and decrements each cycle; at 0, go to DONE.
- DONE (1 cycle):
  - result_valid = 1, wb_en = (rd_o != 0), controls still held.
  - Next state is IDLE; instr_ready rises the cycle after DONE.
  - Total accept-to-result_valid latency is LAT+1 cycles.
- Decode, funct7 = 0000000 / 0100000 (result_sel = 0, Mul_en = 0, Div_en = 0):
  - alu_op: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9.
- Decode, funct7 = 0000001 (result_sel = 1):
  - MUL: M_sel 10, sn 11.
  - MULH: M_sel 11, sn 11.
  - MULHSU: M_sel 11, sn 10.
  - MULHU: M_sel 11, sn 00.
  - DIV: M_sel 00, sn 11.
  - DIVU: M_sel 00, sn 00.
  - REM: M_sel 01, sn 11.
  - REMU: M_sel 01, sn 00.
  - Mul_en = 1 for funct3[2] = 0; Div_en = 1 for funct3[2] = 1.
- In IDLE, alu_op, sn, M_sel and result_sel keep their last values; Mul_en and Div_en are 0.
- flush_i:
  - Has priority in any state: next state IDLE, Mul_en and Div_en cleared, no result_valid.
  - A flush asserted in the same cycle as an accept cancels that accept.
- instr_valid while not ready: ignored; upstream holds the fields.

Optional Feature:
- Macro ALU_ISSUE_DIV0_FAST_EN.
- Defined: a DIV/DIVU/REM/REMU accepted with div_zero_i = 1 loads counter 0, so result_valid arrives 2 cycles after accept.
- Undefined: div_zero_i is ignored and all divides take DIV_LAT.

Decomposition:
- Package alu_issue_pkg holds: the alu_op localparams (ALU_ADD..ALU_AND), M_sel codes (MSEL_QUO/REM/LSB/MSB), opcode/funct7 constants, and the state enum.
- One combinational sub-module, alu_issue_decode, maps funct7/funct3/opcode to {alu_op, sn, Mul_en, Div_en, M_sel, result_sel, lat_class, illegal}.
- Counter and FSM live in the top.

Test Plan:
- ADD x5 (funct7 0, funct3 000, opcode 0110011, rd 5) accepted -> result_valid exactly 2 cycles later; alu_op 0, result_sel 0, wb_en 1, rd_o 5.
- MULHSU rd 3 -> controls Mul_en 1, M_sel 11, sn 10 held for MUL_LAT cycles; instr_ready low until the cycle after result_valid (3 cycles after accept).
- DIVU rd 0, div_zero_i 0 -> result_valid 35 cycles after accept, wb_en 0, Div_en 1, sn 00 throughout; with the macro and div_zero_i 1 -> result_valid after 2 cycles.
- REM accepted, flush_i pulsed 10 cycles later -> IDLE next cycle, no result_valid, Div_en 0, instr_ready 1.
- funct7 0100000 with funct3 111 -> illegal_o one pulse, no stall, no result_valid.
- rst_n low mid-DIV -> all outputs 0 and instr_ready 1 immediately (asynchronously); the first accept after reset behaves normally.
